// File: rtl/hazard_ctrl_mc.sv
// Hazard and forwarding controller for the 5-stage pipeline with a multi-cycle
// execute hold, jump/branch decode flush and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
    parameter int unsigned AWL    = 5,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned SCW    = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [AWL-1:0] rsD,
    input  logic [AWL-1:0] rtD,
    input  logic [AWL-1:0] rsE,
    input  logic [AWL-1:0] rtE,
    input  logic [AWL-1:0] RFAE,
    input  logic [AWL-1:0] RFAM,
    input  logic [AWL-1:0] RFAW,
    input  logic           RFWEE,
    input  logic           RFWEM,
    input  logic           RFWEW,
    input  logic           MtoRFSelE,
    input  logic           MtoRFSelM,
    input  logic           BranchD,
    input  logic           PCSrcD,
    input  logic           JumpD,
    input  logic           MCE,
    output logic           StallF,
    output logic           StallD,
    output logic           FlushD,
    output logic           FlushE,
    output logic           FlushM,
    output logic           HoldE,
    output logic           ForwardAD,
    output logic           ForwardBD,
    output logic [1:0]     ForwardAE,
    output logic [1:0]     ForwardBE,
    output logic           McBusy,
    output logic [SCW-1:0] StallCnt
);

    localparam int unsigned CW = $clog2(MC_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MC_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lwstall, brstall, hold;

    // Address match that never fires on register 0.
    function automatic logic hit(input logic [AWL-1:0] a, input logic [AWL-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Multi-cycle counter, state and stall-cycle counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            StallCnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (StallF && (StallCnt != '1)) begin
                StallCnt <= StallCnt + SCW'(1);
            end
        end
    end

    // Next-state and all combinational hazard/forward outputs.
    always_comb begin
        state_d   = IDLE;
        cnt_d     = '0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        HoldE     = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        McBusy    = (state_q == BUSY);

        lwstall = MtoRFSelE && RFWEE && (hit(RFAE, rsD) || hit(RFAE, rtD));
        brstall = BranchD && ((RFWEE && (hit(RFAE, rsD) || hit(RFAE, rtD))) ||
                              (MtoRFSelM && (hit(RFAM, rsD) || hit(RFAM, rtD))));
        hold    = MCE && (cnt_q != LAST);

        unique case (state_q)
            IDLE: begin
                if (hold) begin
                    state_d = BUSY;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if (hold) begin
                    state_d = BUSY;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
        endcase

        // Reset forces every control output inactive.
        if (!RST) begin
            HoldE  = hold;
            StallF = lwstall || brstall || hold;
            StallD = StallF;
            FlushE = (lwstall || brstall) && !hold;
            FlushM = hold;
            FlushD = (PCSrcD || JumpD) && !StallD;

            ForwardAD = RFWEM && hit(rsD, RFAM);
            ForwardBD = RFWEM && hit(rtD, RFAM);
            if (RFWEM && hit(rsE, RFAM))      ForwardAE = 2'b10;
            else if (RFWEW && hit(rsE, RFAW)) ForwardAE = 2'b01;
            if (RFWEM && hit(rtE, RFAM))      ForwardBE = 2'b10;
            else if (RFWEW && hit(rtE, RFAW)) ForwardBE = 2'b01;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed self-checking bench for hazard_ctrl_mc: main instance (MC_LAT=4),
// a narrow stall counter instance (SCW=4) and a single-cycle instance (MC_LAT=1).
module tb_hazard_ctrl_mc;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] rsD, rtD, rsE, rtE, RFAE, RFAM, RFAW;
    logic       RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, BranchD, PCSrcD, JumpD, MCE;

    logic        StallF, StallD, FlushD, FlushE, FlushM, HoldE, ForwardAD, ForwardBD, McBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCnt;

    logic       s_StallF, s_StallD, s_FlushD, s_FlushE, s_FlushM, s_HoldE, s_FwdAD, s_FwdBD, s_McBusy;
    logic [1:0] s_FwdAE, s_FwdBE;
    logic [3:0] s_StallCnt;

    logic        o_StallF, o_StallD, o_FlushD, o_FlushE, o_FlushM, o_HoldE, o_FwdAD, o_FwdBD, o_McBusy;
    logic [1:0]  o_FwdAE, o_FwdBE;
    logic [15:0] o_StallCnt;

    logic [5:0] ctl, fwd;
    assign ctl = {StallF, StallD, FlushD, FlushE, FlushM, HoldE};
    assign fwd = {ForwardAE, ForwardBE, ForwardAD, ForwardBD};

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;
    int exp_sat = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_mc #(.AWL(5), .MC_LAT(4), .SCW(16)) dut (
        .CLK(CLK), .RST(RST), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .RFAE(RFAE), .RFAM(RFAM), .RFAW(RFAW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
        .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .JumpD(JumpD), .MCE(MCE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .FlushM(FlushM), .HoldE(HoldE), .ForwardAD(ForwardAD),
        .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .McBusy(McBusy), .StallCnt(StallCnt)
    );

    hazard_ctrl_mc #(.AWL(5), .MC_LAT(4), .SCW(4)) dut_sat (
        .CLK(CLK), .RST(RST), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .RFAE(RFAE), .RFAM(RFAM), .RFAW(RFAW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
        .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .JumpD(JumpD), .MCE(MCE), .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD),
        .FlushE(s_FlushE), .FlushM(s_FlushM), .HoldE(s_HoldE), .ForwardAD(s_FwdAD),
        .ForwardBD(s_FwdBD), .ForwardAE(s_FwdAE), .ForwardBE(s_FwdBE),
        .McBusy(s_McBusy), .StallCnt(s_StallCnt)
    );

    hazard_ctrl_mc #(.AWL(5), .MC_LAT(1), .SCW(16)) dut_one (
        .CLK(CLK), .RST(RST), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .RFAE(RFAE), .RFAM(RFAM), .RFAW(RFAW), .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
        .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM), .BranchD(BranchD), .PCSrcD(PCSrcD),
        .JumpD(JumpD), .MCE(MCE), .StallF(o_StallF), .StallD(o_StallD), .FlushD(o_FlushD),
        .FlushE(o_FlushE), .FlushM(o_FlushM), .HoldE(o_HoldE), .ForwardAD(o_FwdAD),
        .ForwardBD(o_FwdBD), .ForwardAE(o_FwdAE), .ForwardBE(o_FwdBE),
        .McBusy(o_McBusy), .StallCnt(o_StallCnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0; RFAE = '0; RFAM = '0; RFAW = '0;
        RFWEE = 0; RFWEM = 0; RFWEW = 0; MtoRFSelE = 0; MtoRFSelM = 0;
        BranchD = 0; PCSrcD = 0; JumpD = 0; MCE = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        MCE = 1; MtoRFSelE = 1; RFWEE = 1; RFAE = 5; rsD = 5;
        RFAM = 3; RFWEM = 1; rsE = 3; PCSrcD = 1;
        #1;
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b0); end
        checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL reset_fwd got=%b exp=%b", fwd, 6'b0); end
        tick(); tick();
        checks++; if (StallCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", StallCnt); end
        checks++; if (McBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", McBusy); end
        RST = 1'b0;
        clear_inputs();
        #1;
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 6'b0); end
        exp_sc = 0;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RFAM = 3; RFAW = 3; RFWEM = 1; RFWEW = 1; rsE = 3; rtE = 3; rsD = 3; rtD = 4;
        #1;
        checks++; if (fwd !== 6'b10_10_1_0) begin errors++; $display("FAIL fwd_m got=%b exp=%b", fwd, 6'b101010); end
        RFWEM = 0;
        #1;
        checks++; if (fwd !== 6'b01_01_0_0) begin errors++; $display("FAIL fwd_w got=%b exp=%b", fwd, 6'b010100); end
        RFWEM = 1; rtE = 4; RFAW = 4; rtD = 3;
        #1;
        checks++; if (fwd !== 6'b10_01_1_1) begin errors++; $display("FAIL fwd_mix got=%b exp=%b", fwd, 6'b100111); end
        rsE = 0; rtE = 0; rsD = 0; rtD = 0; RFAM = 0; RFAW = 0;
        #1;
        checks++; if (fwd !== 6'b0) begin errors++; $display("FAIL fwd_r0 got=%b exp=%b", fwd, 6'b0); end
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL fwd_nostall got=%b exp=%b", ctl, 6'b0); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        MtoRFSelE = 1; RFWEE = 1; RFAE = 5; rtD = 5;
        #1;
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL lw_ctl got=%b exp=%b", ctl, 6'b110100); end
        tick(); exp_sc++;
        RFAE = 0; rtD = 0; rsD = 0;
        #1;
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL lw_r0 got=%b exp=%b", ctl, 6'b0); end
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL lw_cnt got=%0d exp=%0d", StallCnt, exp_sc); end
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchD = 1; rsD = 7; MtoRFSelM = 1; RFAM = 7;
        #1;
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL br_ctl got=%b exp=%b", ctl, 6'b110100); end
        PCSrcD = 1;
        #1;
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL br_taken_stall got=%b exp=%b", ctl, 6'b110100); end
        tick(); exp_sc++;
        MtoRFSelM = 0;
        #1;
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL br_flushd got=%b exp=%b", ctl, 6'b001000); end
        PCSrcD = 0; BranchD = 0; JumpD = 1;
        #1;
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL jump_flushd got=%b exp=%b", ctl, 6'b001000); end
        JumpD = 0; BranchD = 1; RFWEE = 1; RFAE = 9; rtD = 9; rsD = 0;
        #1;
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL br_e_ctl got=%b exp=%b", ctl, 6'b110100); end
        clear_inputs();
        #1;
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL br_cnt got=%0d exp=%0d", StallCnt, exp_sc); end
    endtask

    task automatic test_multicycle();
        logic h, b;
        clear_inputs();
        MCE = 1;
        for (int i = 0; i < 8; i++) begin
            h = ((i % 4) != 3);
            b = ((i % 4) != 0);
            #1;
            checks++; if (ctl !== {h, h, 1'b0, 1'b0, h, h}) begin errors++; $display("FAIL mc_ctl[%0d] got=%b exp=%b", i, ctl, {h, h, 1'b0, 1'b0, h, h}); end
            checks++; if (McBusy !== b) begin errors++; $display("FAIL mc_busy[%0d] got=%b exp=%b", i, McBusy, b); end
            checks++; if ({o_HoldE, o_McBusy} !== 2'b00) begin errors++; $display("FAIL mc_lat1[%0d] got=%b exp=00", i, {o_HoldE, o_McBusy}); end
            tick();
            if (h) exp_sc++;
        end
        MCE = 0;
        #1;
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL mc_cnt got=%0d exp=%0d", StallCnt, exp_sc); end
        checks++; if (McBusy !== 1'b0) begin errors++; $display("FAIL mc_idle got=%b exp=0", McBusy); end
        // Load-use and taken branch while the hold is active, then an aborted op.
        MCE = 1; MtoRFSelE = 1; RFWEE = 1; RFAE = 5; rsD = 5; PCSrcD = 1;
        #1;
        checks++; if (ctl !== 6'b110011) begin errors++; $display("FAIL mc_lw_ctl got=%b exp=%b", ctl, 6'b110011); end
        tick(); exp_sc++;
        MCE = 0;
        #1;
        checks++; if ({ctl, McBusy} !== 7'b1101001) begin errors++; $display("FAIL mc_abort got=%b exp=%b", {ctl, McBusy}, 7'b1101001); end
        tick(); exp_sc++;
        clear_inputs();
        #1;
        checks++; if (McBusy !== 1'b0) begin errors++; $display("FAIL mc_abort_idle got=%b exp=0", McBusy); end
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL mc_cnt2 got=%0d exp=%0d", StallCnt, exp_sc); end
    endtask

    task automatic test_reset_mid_hold();
        logic h, b;
        clear_inputs();
        MCE = 1;
        tick(); tick();
        rsE = 3; RFAM = 3; RFWEM = 1;
        #1;
        checks++; if (McBusy !== 1'b1) begin errors++; $display("FAIL rh_busy got=%b exp=1", McBusy); end
        RST = 1'b1;
        #1;
        checks++; if ({ctl, fwd} !== 12'b0) begin errors++; $display("FAIL rh_forced got=%b exp=%b", {ctl, fwd}, 12'b0); end
        tick();
        RST = 1'b0;
        rsE = 0; RFAM = 0; RFWEM = 0;
        exp_sc = 0; exp_sat = 0;
        #1;
        checks++; if ({StallCnt, s_StallCnt} !== 20'd0) begin errors++; $display("FAIL rh_cnt got=%0d/%0d exp=0/0", StallCnt, s_StallCnt); end
        for (int i = 0; i < 4; i++) begin
            h = (i != 3);
            b = (i != 0);
            #1;
            checks++; if ({HoldE, FlushM, StallF, McBusy} !== {h, h, h, b}) begin errors++; $display("FAIL rh_seq[%0d] got=%b exp=%b", i, {HoldE, FlushM, StallF, McBusy}, {h, h, h, b}); end
            tick();
            if (h) begin exp_sc++; exp_sat++; end
        end
        MCE = 0;
        #1;
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL rh_cnt_after got=%0d exp=%0d", StallCnt, exp_sc); end
    endtask

    task automatic test_saturation();
        clear_inputs();
        MtoRFSelE = 1; RFWEE = 1; RFAE = 6; rsD = 6;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_sc++;
            if (exp_sat < 15) exp_sat++;
            if (i == 11) begin
                checks++; if (s_StallCnt !== 4'(exp_sat)) begin errors++; $display("FAIL sat_reach got=%0d exp=%0d", s_StallCnt, exp_sat); end
            end
        end
        clear_inputs();
        #1;
        checks++; if (s_StallCnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", s_StallCnt); end
        checks++; if (StallCnt !== 16'(exp_sc)) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", StallCnt, exp_sc); end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_reset_mid_hold();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
